// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word loads and stores against a 1-cycle-latency word memory.
// Sub-word stores are done as read-modify-write; misaligned or illegal requests finish at once with err.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  write_ram_flag,
  input  logic [2:0]  load_ram_flag,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  localparam logic [1:0] ST_SW = 2'b01, ST_SH = 2'b10, ST_SB = 2'b11;
  localparam logic [2:0] LD_LW = 3'b001, LD_LHU = 3'b010, LD_LBU = 3'b011,
                         LD_LH = 3'b110, LD_LB  = 3'b111;

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q, merged_q;
  logic [1:0]  wflag_q;
  logic [2:0]  lflag_q;
  logic        err_q;

  // request classification on the incoming (not yet captured) fields
  logic is_load, is_store, illegal, word_acc, half_acc, misaligned, fault, accept;
  always_comb begin
    is_load    = (load_ram_flag != 3'b000);
    is_store   = (write_ram_flag != 2'b00);
    illegal    = (load_ram_flag == 3'b100) || (load_ram_flag == 3'b101) || (is_load && is_store);
    word_acc   = (load_ram_flag == LD_LW) || (write_ram_flag == ST_SW);
    half_acc   = (load_ram_flag == LD_LHU) || (load_ram_flag == LD_LH) || (write_ram_flag == ST_SH);
    misaligned = (word_acc && (addr[1:0] != 2'b00)) || (half_acc && addr[0]);
    fault      = illegal || misaligned;
    accept     = (state == IDLE) && req;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) begin
        if (fault || (!is_load && !is_store)) state_nxt = DONE;
        else if (write_ram_flag == ST_SW)      state_nxt = WR;
        else                                   state_nxt = RD;
      end
      RD:      state_nxt = CAP;
      CAP:     state_nxt = (lflag_q != 3'b000) ? DONE : WR;
      WR:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // per-lane store merge: each byte lane takes store data or keeps the memory byte
  logic [NUM_LANES-1:0][LANE_W-1:0] merged;
  genvar i;
  generate
    for (i = 0; i < NUM_LANES; i++) begin : g_lane
      localparam logic [1:0] LANE = 2'(i);
      logic sel;
      always_comb begin
        sel = ((wflag_q == ST_SB) && (addr_q[1:0] == LANE)) ||
              ((wflag_q == ST_SH) && (addr_q[1] == LANE[1]));
        if (!sel)                    merged[i] = mem_rdata[i*LANE_W +: LANE_W];
        else if (wflag_q == ST_SB)   merged[i] = wdata_q[7:0];
        else                         merged[i] = wdata_q[(i%2)*LANE_W +: LANE_W];
      end
    end
  endgenerate

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_v;
  always_comb begin
    byte_v = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_v = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lflag_q)
      LD_LB:   load_v = {{24{byte_v[7]}}, byte_v};
      LD_LBU:  load_v = {24'h0, byte_v};
      LD_LH:   load_v = {{16{half_v[15]}}, half_v};
      LD_LHU:  load_v = {16'h0, half_v};
      default: load_v = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      wflag_q  <= '0;
      lflag_q  <= '0;
      err_q    <= 1'b0;
      rdata    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        wflag_q <= write_ram_flag;
        lflag_q <= load_ram_flag;
        err_q   <= fault;
      end
      if (state == CAP) begin
        if (lflag_q != 3'b000) rdata    <= load_v;
        else                   merged_q <= merged;
      end
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    err       = done && err_q;
    mem_en    = (state == RD) || (state == WR);
    mem_we    = (state == WR);
    mem_addr  = addr_q[31:2];
    mem_wdata = (wflag_q == ST_SW) ? wdata_q : merged_q;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios then random traffic against a transaction-level model.
module tb_load_store_unit;
  logic        clk, rst, req;
  logic [31:0] addr, wdata;
  logic [1:0]  write_ram_flag;
  logic [2:0]  load_ram_flag;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .wdata(wdata),
    .write_ram_flag(write_ram_flag), .load_ram_flag(load_ram_flag),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bench-side synchronous memory plus a backdoor preload port
  logic [31:0] mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_data;
  int          nrd = 0, nwr = 0;
  logic [31:0] last_wdata = '0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr[7:0]] <= mem_wdata;
        nwr <= nwr + 1;
        last_wdata <= mem_wdata;
      end else begin
        mem_rdata <= mem[mem_addr[7:0]];
        nrd <= nrd + 1;
      end
    end
  end

  logic [31:0] ref_mem [0:255];
  logic [31:0] ref_rdata;
  int nchk = 0, nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = a[9:2]; pre_data = d;
    ref_mem[a[9:2]] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // One transaction: model predicts latency, err, rdata, memory traffic and the final word.
  // Entered and left at the negedge of an IDLE cycle.
  task automatic do_op(input string tag, input logic [2:0] lf, input logic [1:0] wf,
                       input logic [31:0] a, input logic [31:0] wd);
    int sz, off, lat, exp_lat, r0, w0, exp_rd, exp_wr;
    logic ill, mis, exp_err;
    logic [31:0] word, sh, v, mask;
    word = ref_mem[a[9:2]];
    off  = a % 4;
    ill  = (lf == 3'd4) || (lf == 3'd5) || (lf != 0 && wf != 0);
    sz   = (lf == 3'd1 || wf == 2'd1) ? 4 : (lf == 3'd2 || lf == 3'd6 || wf == 2'd2) ? 2 : 1;
    mis  = (a % sz) != 0;
    exp_err = 1'b0; exp_rd = 0; exp_wr = 0;
    if (ill || mis) begin
      exp_lat = 1; exp_err = 1'b1;
    end else if (lf == 0 && wf == 0) begin
      exp_lat = 1;
    end else if (lf != 0) begin
      exp_lat = 3; exp_rd = 1;
      sh = word >> (8 * off);
      case (lf)
        3'd1: v = word;
        3'd2: v = sh & 32'hFFFF;
        3'd3: v = sh & 32'hFF;
        3'd6: begin v = sh & 32'hFFFF; if (v >= 32768) v = v + 32'hFFFF0000; end
        default: begin v = sh & 32'hFF; if (v >= 128) v = v + 32'hFFFFFF00; end
      endcase
      ref_rdata = v;
    end else if (wf == 2'd1) begin
      exp_lat = 2; exp_wr = 1;
      ref_mem[a[9:2]] = wd;
    end else begin
      exp_lat = 4; exp_rd = 1; exp_wr = 1;
      mask = ((sz == 1) ? 32'hFF : 32'hFFFF) << (8 * off);
      ref_mem[a[9:2]] = (word & ~mask) | ((wd << (8 * off)) & mask);
    end
    r0 = nrd; w0 = nwr;
    req = 1'b1; addr = a; wdata = wd; load_ram_flag = lf; write_ram_flag = wf;
    @(negedge clk);
    req = 1'b0;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
    chk({tag, ".rdata"}, rdata, ref_rdata);
    @(negedge clk);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
    chk({tag, ".reads"}, nrd - r0, exp_rd);
    chk({tag, ".writes"}, nwr - w0, exp_wr);
    chk({tag, ".memword"}, mem[a[9:2]], ref_mem[a[9:2]]);
  endtask

  initial begin
    int nd, w0;
    int dc [2];
    bit saw_we;
    logic [2:0]  lf;
    logic [1:0]  wf;
    logic [31:0] a;
    rst = 1'b1; req = 1'b0; addr = '0; wdata = '0;
    write_ram_flag = '0; load_ram_flag = '0;
    pre_we = 1'b0; pre_idx = '0; pre_data = '0;
    ref_rdata = '0;
    for (int k = 0; k < 256; k++) ref_mem[k] = '0;
    #12;
    chk("reset.busy", 32'(busy), 0);
    chk("reset.done", 32'(done), 0);
    chk("reset.err", 32'(err), 0);
    chk("reset.mem_en", 32'(mem_en), 0);
    chk("reset.mem_we", 32'(mem_we), 0);
    chk("reset.rdata", rdata, 0);
    chk("reset.mem_addr", 32'(mem_addr), 0);
    chk("reset.mem_wdata", mem_wdata, 0);

    for (int k = 0; k < 256; k++) preload(32'(k * 4), $urandom);
    preload(32'h100, 32'h12803456);
    preload(32'h200, 32'hAABBCCDD);
    preload(32'h000, 32'h80017FFF);
    preload(32'h040, 32'h11223344);

    @(negedge clk);
    rst = 1'b0;
    // accepted on the first edge after reset release
    do_op("sw", 3'b000, 2'b01, 32'h300, 32'hDEADBEEF);
    chk("sw.data", last_wdata, 32'hDEADBEEF);
    do_op("lb", 3'b111, 2'b00, 32'h102, 32'h0);
    chk("lb.const", rdata, 32'hFFFFFF80);
    do_op("lbu", 3'b011, 2'b00, 32'h102, 32'h0);
    chk("lbu.const", rdata, 32'h00000080);
    do_op("sb", 3'b000, 2'b11, 32'h201, 32'h11);
    chk("sb.merge", last_wdata, 32'hAABB11DD);
    do_op("lw_mis", 3'b001, 2'b00, 32'h102, 32'h0);
    chk("lw_mis.rdata", rdata, 32'h00000080);
    do_op("null", 3'b000, 2'b00, 32'h0, 32'h0);
    do_op("illegal", 3'b100, 2'b00, 32'h0, 32'h0);
    do_op("both", 3'b001, 2'b01, 32'h0, 32'h0);

    // back-to-back LH with req held high
    req = 1'b1; addr = 32'h002; wdata = '0; load_ram_flag = 3'b110; write_ram_flag = 2'b00;
    nd = 0; dc[0] = -1; dc[1] = -1;
    for (int c = 0; c < 20 && nd < 2; c++) begin
      @(negedge clk);
      if (done) begin
        dc[nd] = c;
        nd++;
        chk("b2b.rdata", rdata, 32'hFFFF8001);
        if (nd == 2) req = 1'b0;
      end
    end
    req = 1'b0;
    ref_rdata = 32'hFFFF8001;
    chk("b2b.count", nd, 2);
    chk("b2b.first", dc[0], 2);
    chk("b2b.spacing", dc[1] - dc[0], 4);
    @(negedge clk);

    // reset during the WR of an SH aborts the write
    w0 = nwr; saw_we = 1'b0;
    req = 1'b1; addr = 32'h042; wdata = 32'hBEEF; load_ram_flag = 3'b000; write_ram_flag = 2'b10;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      req = 1'b0;
      if (mem_we) begin saw_we = 1'b1; break; end
    end
    chk("rstwr.reached", 32'(saw_we), 1);
    rst = 1'b1;
    #1;
    chk("rstwr.mem_we", 32'(mem_we), 0);
    chk("rstwr.busy", 32'(busy), 0);
    chk("rstwr.done", 32'(done), 0);
    ref_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("rstwr.nodone", nd, 0);
    chk("rstwr.nowrite", nwr - w0, 0);
    chk("rstwr.word", mem[8'h10], 32'h11223344);
    chk("rstwr.rdata", rdata, 0);

    // random traffic
    for (int n = 0; n < 150; n++) begin
      int kind;
      logic [2:0] loads [5] = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b111};
      kind = $urandom_range(0, 9);
      lf = 3'b000; wf = 2'b00;
      if (kind < 4)      lf = loads[$urandom_range(0, 4)];
      else if (kind < 8) wf = 2'($urandom_range(1, 3));
      else begin lf = 3'($urandom_range(0, 7)); wf = 2'($urandom_range(0, 3)); end
      a = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      else if ($urandom_range(0, 1) != 0) a[0] = 1'b0;
      do_op("rand", lf, wf, a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports exactly as follows (clock and reset first).
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req  in  1  access request; sampled only while busy=0.
REQ-005 addr  in  32  byte address of the access.
REQ-006 wdata  in  32  store data; the low 8, 16 or 32 bits are used.
REQ-007 write_ram_flag  in  2  store code: 00 none, 01 SW, 10 SH, 11 SB.
REQ-008 load_ram_flag  in  3  load code: 000 none, 001 LW, 010 LHU, 011 LBU, 110 LH, 111 LB; 100 and 101 are invalid.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 err  out  1  valid with done; marks a misaligned or illegal access.
REQ-012 rdata  out  32  load result, extended to 32 bits.
REQ-013 mem_en  out  1  word-memory enable.
REQ-014 mem_we  out  1  word-memory write enable.
REQ-015 mem_addr  out  30  word address, equal to addr[31:2].
REQ-016 mem_wdata  out  32  full word written to memory.
REQ-017 mem_rdata  in  32  read data from a synchronous memory with 1-cycle read latency.

Function
REQ-018 Acceptance: in cycle T with req=1 and busy=0, the block SHALL register addr, wdata and both flags; req while busy=1 SHALL be ignored.
REQ-019 FSM states SHALL be IDLE, RD, CAP, WR and DONE.
- DONE always returns to IDLE on the next cycle.
- done=1 only in DONE.
REQ-020 Load path SHALL be IDLE(T) -> RD(T+1) -> CAP(T+2) -> DONE(T+3).
- RD: mem_en=1, mem_we=0.
- CAP: mem_rdata sampled into rdata.
REQ-021 SW path SHALL be IDLE(T) -> WR(T+1) -> DONE(T+2).
- WR: mem_en=1, mem_we=1, mem_wdata=wdata.
- No memory read.
REQ-022 SH/SB path SHALL be IDLE(T) -> RD(T+1) -> CAP(T+2) -> WR(T+3) -> DONE(T+4), as a read-modify-write.
- CAP: the merged word is registered.
- WR: the merged word is written.
REQ-023 Byte merge SHALL replace byte lane addr[1:0] with wdata[7:0]; other bytes are unchanged.
REQ-024 Halfword merge SHALL replace halfword lane addr[1] with wdata[15:0]; the other half is unchanged.
REQ-025 Load extraction SHALL use the same lanes.
- LB/LH: sign-extend.
- LBU/LHU: zero-extend.
- LW: full word.
REQ-026 Misaligned accesses SHALL go IDLE -> DONE at T+1 with err=1, no memory access and rdata unchanged.
- LW/SW misaligned when addr[1:0]!=0.
- LH/LHU/SH misaligned when addr[0]!=0.
REQ-027 Illegal requests SHALL take the same err=1 path as REQ-026. Illegal means load_ram_flag 100/101, or both flags nonzero.
REQ-028 Null request (both flags zero) SHALL go IDLE -> DONE at T+1 with err=0 and no memory access.
REQ-029 Memory outputs SHALL be combinational from the state and captured registers.
- mem_en=0 in IDLE, CAP and DONE.
- mem_addr holds the captured word address while busy.
REQ-030 rdata SHALL hold its value until the next successful load completes; stores never modify it.
REQ-031 A new req in the DONE cycle SHALL be ignored; the earliest next acceptance is the following IDLE cycle.

Reset
REQ-032 rst=1 SHALL immediately force state IDLE and busy=done=err=mem_en=mem_we=0, with rdata, mem_addr and mem_wdata = 0.
REQ-033 Reset mid-operation SHALL abort the access: a pending WR is not performed and no done is emitted.
REQ-034 After rst deasserts, the block SHALL accept req on the first rising clock edge.

Verification
REQ-035 LB sign: memory word 0x12_80_34_56 at 0x100; LB addr 0x102 -> done at T+3, err=0, rdata=0xFFFFFF80. LBU at the same address -> rdata=0x00000080.
REQ-036 SB merge: memory 0xAABBCCDD at 0x200; SB addr 0x201, wdata=0x11 -> WR at T+3 with mem_wdata=0xAABB11DD, done at T+4.
REQ-037 SW: addr 0x300, wdata 0xDEADBEEF -> mem_en=mem_we=1 at T+1, no read, done at T+2.
REQ-038 Misaligned: LW addr 0x102 -> done at T+1, err=1, mem_en stays 0, rdata unchanged.
REQ-039 Reset in WR of an SH -> mem_we drops immediately, no done, memory word unchanged.
REQ-040 Back-to-back: req held high across two LH requests (addr 0x002 over word 0x8001_7FFF) -> second accepted one cycle after the first done; rdata = 0xFFFF8001, each access with 4-cycle spacing.
